display_driver: RTL and testbench

//  Consumer of the CPU's 32-bit `display` word.
//  - Converts the word to BCD with a sequential double-dabble.
//  - Drives a time-multiplexed bank of active-low seven-segment digits.
//  - Sits at the top level beside the CPU; clocked directly by the board clock.
//  - Only the low DIGITS decimal digits are shown; an overflow flag marks larger values.

---
 rtl/display_driver.sv | 170 +++++++++++++++++
 tb/tb_display_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a multiplexed,
// active-low seven-segment display with optional leading-zero blanking.
module display_driver #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic [31:0]       display,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic [39:0]       bcd,
  output logic              overflow,
  output logic              busy
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state_r;
  logic [31:0]       last_r;
  logic [31:0]       shift_r;
  logic [39:0]       work_r;
  logic [39:0]       work_adj_s;
  logic [5:0]        cnt_r;
  logic              ovf_s;
  logic [CW-1:0]     scan_cnt_r;
  logic [IW-1:0]     scan_idx_r;
  logic [3:0]        nib_s;
  logic              blank_s;
  logic [DIGITS-1:0] lz_s;
  logic              zero_run_s;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Double-dabble correction: every work nibble >= 5 gets +3 before the shift
  always_comb begin
    work_adj_s = work_r;
    for (int i = 0; i < 10; i++) begin
      if (work_r[4*i +: 4] >= 4'd5) begin
        work_adj_s[4*i +: 4] = work_r[4*i +: 4] + 4'd3;
      end else begin
        work_adj_s[4*i +: 4] = work_r[4*i +: 4];
      end
    end
  end

  // Overflow is any non-zero nibble above the physical digit count
  always_comb begin
    ovf_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i >= DIGITS) begin
        ovf_s = ovf_s | (work_r[4*i +: 4] != 4'd0);
      end else begin
        ovf_s = ovf_s;
      end
    end
  end

  // Conversion FSM: capture on change, 32 shift steps, one commit cycle
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      last_r   <= 32'd0;
      shift_r  <= 32'd0;
      work_r   <= 40'd0;
      cnt_r    <= 6'd0;
      bcd      <= 40'd0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (display != last_r) begin
            shift_r <= display;
            last_r  <= display;
            work_r  <= 40'd0;
            cnt_r   <= 6'd0;
            busy    <= 1'b1;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          {work_r, shift_r} <= {work_adj_s[38:0], shift_r, 1'b0};
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == 6'd31) begin
            state_r <= COMMIT;
          end
        end
        COMMIT: begin
          bcd      <= work_r;
          overflow <= ovf_s;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Leading-zero mask from the committed value; overflow forces every digit on
  always_comb begin
    zero_run_s = 1'b1;
    lz_s       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run_s = zero_run_s & (bcd[4*k +: 4] == 4'd0);
      lz_s[k]    = zero_run_s & (k != 0) & (BLANK_LZ != 0) & ~overflow;
    end
  end

  // Select the nibble and blank flag for the digit currently scanned
  always_comb begin
    nib_s   = 4'd0;
    blank_s = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx_r == IW'(k)) begin
        nib_s   = bcd[4*k +: 4];
        blank_s = lz_s[k];
      end else begin
        nib_s   = nib_s;
        blank_s = blank_s;
      end
    end
  end

  // Digit scan: free-running divider, round-robin index, registered an/seg
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      scan_cnt_r <= '0;
      scan_idx_r <= '0;
      an         <= ~AN_ONE;
      seg        <= 7'b1000000;
    end else begin
      if (scan_cnt_r == CW'(SCAN_DIV - 1)) begin
        scan_cnt_r <= '0;
        scan_idx_r <= (scan_idx_r == IW'(DIGITS - 1)) ? IW'(0) : scan_idx_r + IW'(1);
      end else begin
        scan_cnt_r <= scan_cnt_r + CW'(1);
      end
      an  <= ~(AN_ONE << scan_idx_r);
      seg <= blank_s ? 7'b1111111 : seg7(nib_s);
    end
  end

endmodule

// File: tb/tb_display_driver.sv
// Scoreboard bench for display_driver: randomized values, decimal reference
// model, commit monitor plus continuous scan/segment checking.
module tb_display_driver;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;

  logic        clk_fpga = 1'b0;
  logic        reset    = 1'b0;
  logic [31:0] display  = 32'd0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [39:0] bcd;
  logic        overflow;
  logic        busy;

  display_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
    .clk_fpga(clk_fpga), .reset(reset), .display(display),
    .an(an), .seg(seg), .bcd(bcd), .overflow(overflow), .busy(busy)
  );

  always #5 clk_fpga = ~clk_fpga;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_last = 32'd0;
  bit          done = 1'b0;

  function automatic logic [39:0] to_bcd(logic [31:0] v);
    longint unsigned x = 64'(v);
    logic [39:0] r = 40'd0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit ovf_of(logic [31:0] v);
    return 64'(v) >= 64'd100000000;
  endfunction

  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(logic [31:0] v, int k);
    longint unsigned x = 64'(v);
    longint unsigned p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    if (!ovf_of(v) && k > 0 && x < p) return 7'h7F;
    return glyph(int'((x / p) % 10));
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(logic [31:0] v, int hold);
    @(negedge clk_fpga);
    display = v;
    if (v != model_last) begin
      exp_q.push_back(v);
      model_last = v;
    end
    repeat (hold) @(negedge clk_fpga);
  endtask

  // Monitor: commits, held bcd, segment content and scan cadence
  logic [31:0] shown = 32'd0;
  int          age = 2, busy_len = 0, hold = 0, dig;
  bit          prev_busy = 1'b0, first_hold = 1'b1;
  logic [7:0]  prev_an = 8'hFE;
  logic [31:0] v;

  always @(negedge clk_fpga) begin
    if (!reset) begin
      chk("rst_bcd", 64'(bcd), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_an", 64'(an), 64'hFE);
      chk("rst_seg", 64'(seg), 64'h40);
      prev_busy = 1'b0; busy_len = 0; shown = 32'd0; age = 2;
      prev_an = 8'hFE; first_hold = 1'b1; hold = 0;
    end else begin
      if (age < 1000) age++;
      if (busy) busy_len++;
      if (prev_busy && !busy) begin
        chk("commit_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          v = exp_q.pop_front();
          chk("commit_bcd", 64'(bcd), 64'(to_bcd(v)));
          chk("commit_ovf", 64'(overflow), 64'(ovf_of(v)));
          chk("busy_cycles", 64'(busy_len), 64'd33);
          shown = v;
          age = 0;
        end
      end
      if (!busy) busy_len = 0;
      prev_busy = busy;
      if (age >= 2) begin
        chk("bcd_hold", 64'(bcd), 64'(to_bcd(shown)));
        dig = 0;
        for (int k = 0; k < DIGITS; k++) if (!an[k]) dig = k;
        chk("seg_digit", 64'(seg), 64'(exp_seg(shown, dig)));
      end
      if (an != prev_an) begin
        chk("an_next", 64'(an), 64'({prev_an[6:0], prev_an[7]}));
        if (!first_hold) chk("an_hold", 64'(hold), 64'(SCAN_DIV));
        first_hold = 1'b0;
        hold = 1;
        prev_an = an;
      end else begin
        hold++;
      end
      if (done) begin
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    int d;
    longint unsigned m;
    logic [31:0] a, b;
    reset = 1'b0;
    repeat (3) @(negedge clk_fpga);
    #2 reset = 1'b1;
    repeat (10) @(negedge clk_fpga);

    apply(32'd1234, 70);
    apply(32'd99999999, 70);
    apply(32'd100000000, 70);
    apply(32'hFFFFFFFF, 70);
    apply(32'hFFFFFFFF, 50);

    // changes during a conversion: 7 is overwritten before the FSM is idle
    apply(32'd5, 11);
    display = 32'd7;
    repeat (5) @(negedge clk_fpga);
    apply(32'd9, 70);

    // reset in the middle of a shift sequence
    apply(32'd777, 20);
    @(posedge clk_fpga);
    #2 reset = 1'b0;
    model_last = 32'd0;
    repeat (3) @(negedge clk_fpga);
    #2 reset = 1'b1;
    if (display != model_last) model_last = display;
    repeat (70) @(negedge clk_fpga);

    for (int n = 0; n < 25; n++) begin
      d = $urandom_range(1, 10);
      m = 1;
      for (int j = 0; j < d; j++) m = m * 10;
      a = (d == 10) ? $urandom : 32'(64'($urandom) % m);
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom;
        apply(a, 5);
        apply(b, 70);
      end else begin
        apply(a, 70);
      end
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_fpga);
    done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

endmodule
